dmem_mmio_responder: RTL
========================

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width of the data bus.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 MemRead  input  1  load request, MEM stage.
REQ-007 MemWrite  input  1  store request, MEM stage.
REQ-008 addr  input  DM_ADDRESS  byte address.
REQ-009 wr_data  input  DATA_W  store data; low bytes are used for SB and SH.
REQ-010 Funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rd_data  output  DATA_W  load data, combinational.
REQ-012 led  output  8  LED register.
REQ-013 timer_irq  output  1  timer interrupt, level.
REQ-014 misalign_err  output  1  copy of status bit 2.

Function
REQ-015 Address map:
- RAM: 0x000-0x1EF, 496 bytes, little-endian.
- MMIO words:
  - 0x1F0 LED: bits[7:0] RW, other bits read 0.
  - 0x1F4 CNT: RW.
  - 0x1F8 CMP: RW.
  - 0x1FC STAT: bit0 match (W1C), bit1 irq_en (RW), bit2 err (W1C), other bits 0.
REQ-016 Reads SHALL be combinational in the request cycle; rd_data = 0 when MemRead = 0.
REQ-017 Writes SHALL commit at the rising edge of the request cycle and be visible the following cycle.
REQ-018 If MemRead and MemWrite are both high, rd_data SHALL return the pre-write contents.
REQ-019 RAM loads SHALL extend as follows:
- LB, LH: sign-extend to 32 bits.
- LBU, LHU: zero-extend.
- LW: return the 4 bytes at addr..addr+3.
REQ-020 RAM stores SHALL write only the addressed byte (SB), two bytes (SH) or four bytes (SW).
REQ-021 Alignment rules:
- B/BU: any address.
- H/HU: addr[0] = 0.
- W: addr[1:0] = 00.
- MMIO: Funct3 SHALL be 010 and addr[1:0] = 00.
REQ-022 The following SHALL count as illegal:
- misaligned access;
- loads with Funct3 011, 110 or 111;
- stores with Funct3 other than 000, 001 or 010;
- a RAM access whose last byte exceeds 0x1EF.
REQ-023 Effects of an illegal access:
- rd_data SHALL be 0.
- No state SHALL be modified.
- STAT.err SHALL set at the next edge.
REQ-024 CNT SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0; a CNT write SHALL load wr_data in place of the increment.
REQ-025 Reads of CNT SHALL return the current, pre-increment value.
REQ-026 STAT.match SHALL set at the edge ending any cycle in which CNT == CMP.
REQ-027 Sticky-bit priority: when a set and a W1C hit STAT.match or STAT.err in the same cycle, the set SHALL win.
REQ-028 timer_irq SHALL equal STAT.match AND STAT.irq_en, with no extra register stage.
REQ-029 led SHALL equal LED[7:0] directly.

Reset
REQ-030 On reset the block SHALL apply these values at the next edge:
- RAM = 0, LED = 0, CNT = 0, CMP = 0xFFFFFFFF, STAT = 0;
- hence led = 0, timer_irq = 0, misalign_err = 0.
REQ-031 Reset SHALL override any write or increment in the same cycle.
REQ-032 The first cycle after reset deasserts SHALL read CNT = 0.

Verification
REQ-033 SW 0xDEADBEEF to 0x010, then:
- LB 0x013 -> 0xFFFFFFDE;
- LBU 0x011 -> 0x000000BE;
- LH 0x010 -> 0xFFFFBEEF;
- LHU 0x012 -> 0x0000DEAD.
REQ-034 Misaligned store and recovery:
- SH 0x12345678 to 0x011 -> misalign_err = 1 next cycle, and LW 0x010 is unchanged.
- SW 0x00000004 to 0x1FC -> misalign_err = 0 next cycle.
REQ-035 Timer interrupt:
- After reset, write CMP = 20 and STAT = 0x2.
- timer_irq rises exactly one cycle after the cycle in which CNT reads 20, and stays high.
- SW 0x1 to STAT clears it.
REQ-036 Boundary and LED cases:
- SW 0x000000A5 to 0x1F0 -> led = 0xA5 next cycle, and LW 0x1F0 = 0x000000A5.
- SW 0xFFFFFFFF to 0x1F4 -> the next read gives 0xFFFFFFFF and the one after gives 0x00000000.
- LW 0x1EE -> rd_data = 0 and err sets.
REQ-037 Reset mid-operation:
- Assert reset in the same cycle as SW 0x11 to 0x1F0 with CNT = 50.
- Next cycle: led = 0, CNT reads 0, LW 0x010 = 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: byte-addressed data RAM with LED, free-running counter, compare and status MMIO words
module dmem_mmio_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            Funct3,
  output logic [DATA_W-1:0]     rd_data,
  output logic [7:0]            led,
  output logic                  timer_irq,
  output logic                  misalign_err
);
  localparam int AW = DM_ADDRESS + 1;
  localparam int RAM_BYTES = (1 << DM_ADDRESS) - 16;
  localparam logic [DM_ADDRESS-1:0] RAM_END = DM_ADDRESS'(RAM_BYTES);
  logic [8*RAM_BYTES-1:0] ram;
  logic [7:0] led_q;
  logic [DATA_W-1:0] cnt, cmp, ram_rd, mmio_rd;
  logic match, irq_en, err;
  logic is_mmio, access, size_ok, align_ok, range_ok, legal, err_ev, wr_ok;
  logic wr_led, wr_cnt, wr_cmp, wr_stat;
  logic [2:0] nbytes;
  logic [AW-1:0] last;
  logic [31:0] word;
  assign is_mmio = addr >= RAM_END;
  assign access = MemRead | MemWrite;
  assign nbytes = 3'd1 << Funct3[1:0];
  assign size_ok = (!MemWrite || Funct3 inside {3'b000, 3'b001, 3'b010}) &&
                   (!MemRead || Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign align_ok = (addr[1:0] & 2'(nbytes - 3'd1)) == 2'b00;
  assign last = {1'b0, addr} + AW'(nbytes) - AW'(1);
  assign range_ok = last < {1'b0, RAM_END};
  assign legal = is_mmio ? (Funct3 == 3'b010 && addr[1:0] == 2'b00) : (size_ok && align_ok && range_ok);
  assign err_ev = access & ~legal;
  assign wr_ok = MemWrite & legal;
  assign wr_led = wr_ok && is_mmio && addr[3:2] == 2'd0;
  assign wr_cnt = wr_ok && is_mmio && addr[3:2] == 2'd1;
  assign wr_cmp = wr_ok && is_mmio && addr[3:2] == 2'd2;
  assign wr_stat = wr_ok && is_mmio && addr[3:2] == 2'd3;
  always_comb begin
    word = '0;
    for (int k = 0; k < 4; k++)
      word[8*k +: 8] = (addr + DM_ADDRESS'(k) < RAM_END) ? ram[{addr + DM_ADDRESS'(k), 3'b000} +: 8] : 8'h00;
  end
  assign ram_rd = Funct3 == 3'b000 ? {{(DATA_W-8){word[7]}}, word[7:0]} :
                  Funct3 == 3'b001 ? {{(DATA_W-16){word[15]}}, word[15:0]} :
                  Funct3 == 3'b100 ? DATA_W'(word[7:0]) :
                  Funct3 == 3'b101 ? DATA_W'(word[15:0]) : DATA_W'(word);
  assign mmio_rd = addr[3:2] == 2'd0 ? DATA_W'(led_q) :
                   addr[3:2] == 2'd1 ? cnt :
                   addr[3:2] == 2'd2 ? cmp : DATA_W'({err, irq_en, match});
  assign rd_data = (MemRead && legal) ? (is_mmio ? mmio_rd : ram_rd) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ram <= '0;
      led_q <= '0;
      cnt <= '0;
      cmp <= '1;
      match <= 1'b0;
      irq_en <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= wr_cnt ? wr_data : cnt + DATA_W'(1);
      if (wr_led) led_q <= wr_data[7:0];
      if (wr_cmp) cmp <= wr_data;
      if (wr_stat) irq_en <= wr_data[1];
      match <= (cnt == cmp) | (match & ~(wr_stat & wr_data[0]));
      err <= err_ev | (err & ~(wr_stat & wr_data[2]));
      if (wr_ok && !is_mmio)
        for (int k = 0; k < 4; k++)
          if (k < int'(nbytes)) ram[{addr + DM_ADDRESS'(k), 3'b000} +: 8] <= wr_data[8*k +: 8];
    end
  end
  assign led = led_q;
  assign timer_irq = match & irq_en;
  assign misalign_err = err;
endmodule
